// File: rtl/mtx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : mtx_serializer_if
// Description : Handshake bundle for the MIO transmit serializer.
//               Emesh side : access_in, packet_in, emode -> wait_out
//               IO side    : io_access, io_packet, io_valid <- io_wait
//               slave  modport : serializer view
//               master modport : core/pin-driver view
// Parameters  : PW - emesh packet width (bits)
//               NW - IO beat width (bytes)
// Revision    : 1.0 - initial release
// ============================================================================
interface mtx_serializer_if #(
    parameter int PW = 136,
    parameter int NW = 8
);
    logic              access_in;
    logic [PW-1:0]     packet_in;
    logic              emode;
    logic              wait_out;
    logic              io_access;
    logic [NW*8-1:0]   io_packet;
    logic [NW-1:0]     io_valid;
    logic              io_wait;

    modport slave (
        input  access_in, packet_in, emode, io_wait,
        output wait_out, io_access, io_packet, io_valid
    );

    modport master (
        output access_in, packet_in, emode, io_wait,
        input  wait_out, io_access, io_packet, io_valid
    );
endinterface
`default_nettype wire

// File: rtl/mtx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : mtx_serializer
// Description : MIO transmit serializer. Buffers emesh packets in a small
//               FIFO and slices each one into NW-byte IO beats with byte
//               valids. Full-packet mode sends all packet bytes; data-only
//               mode sends {srcaddr[31:0], data[31:0]} trimmed to the
//               datamode size. io_wait stalls at beat granularity.
// Ports       : clk        core clock (posedge)
//               nreset     asynchronous active-low reset
//               tx_en      transmit enable (gates new pops and pushes)
//               bus        mtx_serializer_if.slave (emesh in, IO beats out)
//               busy       buffer non-empty or packet in flight
//               pkt_count  packets sent (only with MTX_STATS_EN)
// Options     : MTX_STATS_EN - when defined, pkt_count counts completed
//               packets (wrapping); otherwise it is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mtx_serializer #(
    parameter int PW    = 136,
    parameter int AW    = 64,
    parameter int NW    = 8,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           tx_en,
    mtx_serializer_if.slave bus,
    output logic           busy,
    output logic [31:0]    pkt_count
);

    // Packet bytes, stream bytes rounded up to a whole number of beats so the
    // slicer can shift by exactly one beat without running off the end.
    localparam int c_PB    = (PW + 7) / 8;
    localparam int c_SB    = (c_PB > 8) ? c_PB : 8;
    localparam int c_SBP   = ((c_SB + NW - 1) / NW) * NW;
    localparam int c_SW    = c_SBP * 8;
    localparam int c_RW    = $clog2(c_SBP + 1);
    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_SRC_W = (AW < 32) ? AW : 32;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SEND = 1'b1;

    // ------------------------------------------------------------------
    // Packet buffer: entry = {emode, packet}
    // ------------------------------------------------------------------
    logic [PW:0]        r_mem [DEPTH];
    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [c_AW:0]      w_wr_ptr_nxt;
    logic [c_AW:0]      w_rd_ptr_nxt;
    logic               w_empty;
    logic               w_full;
    logic               w_full_nxt;
    logic               w_push;
    logic               w_pop;

    // ------------------------------------------------------------------
    // Slicer / FSM state
    // ------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [c_SW-1:0]    r_stream;
    logic [c_RW-1:0]    r_remain;
    logic               r_wait_out;
    logic               r_io_access;
    logic [NW*8-1:0]    r_io_packet;
    logic [NW-1:0]      r_io_valid;

    logic               w_accept;
    logic               w_last;
    logic [PW:0]        w_head;
    logic [31:0]        w_srcaddr;
    logic [31:0]        w_data;
    logic [c_SW-1:0]    w_head_stream;
    logic [c_RW-1:0]    w_head_remain;
    logic [c_SW-1:0]    w_sel_stream;
    logic [c_RW-1:0]    w_sel_remain;
    logic [NW*8-1:0]    w_beat_data;
    logic [NW-1:0]      w_beat_valid;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                        (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);

    assign w_accept   = r_io_access & ~bus.io_wait;
    assign w_last     = (r_remain <= c_RW'(NW));

    // r_wait_out already covers a full buffer; the w_full term only keeps the
    // FIFO safe if that ever slips.
    assign w_push     = bus.access_in & ~r_wait_out & ~w_full;
    assign w_pop      = tx_en & ~w_empty &
                        ((r_state == c_ST_IDLE) | (w_accept & w_last));

    assign w_wr_ptr_nxt = r_wr_ptr + {{c_AW{1'b0}}, w_push};
    assign w_rd_ptr_nxt = r_rd_ptr + {{c_AW{1'b0}}, w_pop};
    assign w_full_nxt   = (w_wr_ptr_nxt[c_AW-1:0] == w_rd_ptr_nxt[c_AW-1:0]) &&
                          (w_wr_ptr_nxt[c_AW] != w_rd_ptr_nxt[c_AW]);

    // Build the byte stream for the head entry.
    always_comb begin
        w_head        = r_mem[r_rd_ptr[c_AW-1:0]];
        w_srcaddr     = '0;
        w_srcaddr[c_SRC_W-1:0] = w_head[72 +: c_SRC_W];
        w_data        = w_head[71:40];
        w_head_stream = '0;
        w_head_remain = '0;
        if (w_head[PW]) begin
            w_head_stream[PW-1:0] = w_head[PW-1:0];
            w_head_remain         = c_RW'(c_PB);
        end else begin
            w_head_stream[63:0]   = {w_srcaddr, w_data};
            w_head_remain         = c_RW'(1) << w_head[2:1];
        end
    end

    // Next beat comes either from a freshly popped packet or from the
    // current stream advanced by one beat.
    always_comb begin
        if (w_pop) begin
            w_sel_stream = w_head_stream;
            w_sel_remain = w_head_remain;
        end else begin
            w_sel_stream = r_stream >> (NW * 8);
            w_sel_remain = r_remain - c_RW'(NW);
        end
        w_beat_data  = '0;
        w_beat_valid = '0;
        for (int i = 0; i < NW; i++) begin
            if (c_RW'(i) < w_sel_remain) begin
                w_beat_valid[i]       = 1'b1;
                w_beat_data[i*8 +: 8] = w_sel_stream[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {bus.emode, bus.packet_in};
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_wait_out  <= 1'b0;
            r_state     <= c_ST_IDLE;
            r_stream    <= '0;
            r_remain    <= '0;
            r_io_access <= 1'b0;
            r_io_packet <= '0;
            r_io_valid  <= '0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            // Registered from the next-cycle fill level, so a full buffer that
            // is popped this cycle still shows wait_out this cycle.
            r_wait_out <= w_full_nxt | ~tx_en;

            if (w_pop) begin
                r_state     <= c_ST_SEND;
                r_stream    <= w_sel_stream;
                r_remain    <= w_sel_remain;
                r_io_access <= 1'b1;
                r_io_packet <= w_beat_data;
                r_io_valid  <= w_beat_valid;
            end else if (w_accept && !w_last) begin
                r_stream    <= w_sel_stream;
                r_remain    <= w_sel_remain;
                r_io_packet <= w_beat_data;
                r_io_valid  <= w_beat_valid;
            end else if (w_accept) begin
                r_state     <= c_ST_IDLE;
                r_stream    <= '0;
                r_remain    <= '0;
                r_io_access <= 1'b0;
                r_io_packet <= '0;
                r_io_valid  <= '0;
            end
        end
    end

    assign bus.wait_out  = r_wait_out;
    assign bus.io_access = r_io_access;
    assign bus.io_packet = r_io_packet;
    assign bus.io_valid  = r_io_valid;
    assign busy          = ~w_empty | (r_state == c_ST_SEND);

`ifdef MTX_STATS_EN
    logic [31:0] r_pkt_count;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_pkt_count <= 32'h0;
        end else if (w_accept && w_last) begin
            r_pkt_count <= r_pkt_count + 32'd1;
        end
    end

    assign pkt_count = r_pkt_count;
`else
    assign pkt_count = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mtx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mtx_serializer
// Description : Self-checking bench for mtx_serializer. Two instances:
//               u_dut8 (NW=8, AW=32) and u_dut2 (NW=2, AW=64). Expected
//               beats are queued when packets are accepted and popped as the
//               DUT hands beats over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mtx_serializer;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  valid;
    } beat_t;

    logic        clk    = 1'b0;
    logic        nreset = 1'b0;
    logic        tx_en  = 1'b1;
    logic        busy8, busy2;
    logic [31:0] cnt8, cnt2;

    int    total = 0;
    int    bad   = 0;
    int    pops2 = 0;
    beat_t q8[$];
    beat_t q2[$];

    mtx_serializer_if #(.PW(136), .NW(8)) bus8 ();
    mtx_serializer_if #(.PW(136), .NW(2)) bus2 ();

    mtx_serializer #(.PW(136), .AW(32), .NW(8), .DEPTH(DEPTH)) u_dut8 (
        .clk(clk), .nreset(nreset), .tx_en(tx_en), .bus(bus8),
        .busy(busy8), .pkt_count(cnt8)
    );

    mtx_serializer #(.PW(136), .AW(64), .NW(2), .DEPTH(DEPTH)) u_dut2 (
        .clk(clk), .nreset(nreset), .tx_en(tx_en), .bus(bus2),
        .busy(busy2), .pkt_count(cnt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference byte stream and beat slicing for one packet.
    task automatic model(input logic [135:0] pkt, input logic em, input int nw);
        logic [7:0]  sb [24];
        logic [63:0] s;
        int          cnt;
        beat_t       b;
        for (int i = 0; i < 24; i++) sb[i] = 8'h00;
        if (em) begin
            cnt = 17;
            for (int i = 0; i < 17; i++) sb[i] = pkt[i*8 +: 8];
        end else begin
            s   = {pkt[103:72], pkt[71:40]};
            cnt = 1 << pkt[2:1];
            for (int i = 0; i < 8; i++) sb[i] = s[i*8 +: 8];
        end
        for (int k = 0; k * nw < cnt; k++) begin
            b = '0;
            for (int i = 0; i < nw; i++) begin
                if (k * nw + i < cnt) begin
                    b.data[i*8 +: 8] = sb[k*nw + i];
                    b.valid[i]       = 1'b1;
                end
            end
            if (nw == 8) q8.push_back(b);
            else         q2.push_back(b);
        end
    endtask

    function automatic logic [135:0] rand_pkt(input logic [1:0] dm);
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        r[2:1] = dm;
        return r[135:0];
    endfunction

    task automatic push8(input logic [135:0] pkt, input logic em);
        int guard = 0;
        bus8.access_in = 1'b1;
        bus8.packet_in = pkt;
        bus8.emode     = em;
        @(negedge clk);
        while (bus8.wait_out && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("push8_timeout", 64'(guard >= 200), 64'd0);
        model(pkt, em, 8);
        @(posedge clk); #1;
        bus8.access_in = 1'b0;
    endtask

    task automatic push2(input logic [135:0] pkt, input logic em);
        int guard = 0;
        bus2.access_in = 1'b1;
        bus2.packet_in = pkt;
        bus2.emode     = em;
        @(negedge clk);
        while (bus2.wait_out && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("push2_timeout", 64'(guard >= 200), 64'd0);
        model(pkt, em, 2);
        @(posedge clk); #1;
        bus2.access_in = 1'b0;
    endtask

    task automatic drain8();
        int guard = 0;
        @(posedge clk);
        while ((q8.size() != 0 || busy8) && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        check("drain8_timeout", 64'(guard >= 500), 64'd0);
        #1;
    endtask

    // Beat monitor, NW=8 instance.
    initial begin
        logic        hold = 1'b0;
        logic [63:0] pd;
        logic [7:0]  pv;
        beat_t       e;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                hold = 1'b0;
            end else if (bus8.io_access) begin
                if (hold) begin
                    check("d8_hold_data", bus8.io_packet, pd);
                    check("d8_hold_valid", 64'(bus8.io_valid), 64'(pv));
                end
                if (!bus8.io_wait) begin
                    hold = 1'b0;
                    if (q8.size() == 0) begin
                        check("d8_unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        e = q8.pop_front();
                        check("d8_beat_data", bus8.io_packet, e.data);
                        check("d8_beat_valid", 64'(bus8.io_valid), 64'(e.valid));
                    end
                end else begin
                    hold = 1'b1;
                    pd   = bus8.io_packet;
                    pv   = bus8.io_valid;
                end
            end else begin
                check("d8_dropped_held_beat", 64'(hold), 64'd0);
                check("d8_idle_zero", {bus8.io_packet[55:0], bus8.io_valid}, 64'd0);
                hold = 1'b0;
            end
        end
    end

    // Beat monitor, NW=2 instance.
    initial begin
        logic        hold = 1'b0;
        logic [15:0] pd;
        logic [1:0]  pv;
        beat_t       e;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                hold = 1'b0;
            end else if (bus2.io_access) begin
                if (hold) begin
                    check("d2_hold_data", 64'(bus2.io_packet), 64'(pd));
                    check("d2_hold_valid", 64'(bus2.io_valid), 64'(pv));
                end
                if (!bus2.io_wait) begin
                    hold = 1'b0;
                    if (q2.size() == 0) begin
                        check("d2_unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        e = q2.pop_front();
                        pops2++;
                        check("d2_beat_data", 64'(bus2.io_packet), e.data);
                        check("d2_beat_valid", 64'(bus2.io_valid), 64'(e.valid));
                    end
                end else begin
                    hold = 1'b1;
                    pd   = bus2.io_packet;
                    pv   = bus2.io_valid;
                end
            end else begin
                check("d2_dropped_held_beat", 64'(hold), 64'd0);
                check("d2_idle_zero", {46'd0, bus2.io_packet, bus2.io_valid}, 64'd0);
                hold = 1'b0;
            end
        end
    end

    initial begin
        logic [135:0] pk [6];
        logic [135:0] p;
        int           n;
        int           guard;

        bus8.access_in = 1'b0; bus8.packet_in = '0; bus8.emode = 1'b0; bus8.io_wait = 1'b0;
        bus2.access_in = 1'b0; bus2.packet_in = '0; bus2.emode = 1'b0; bus2.io_wait = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wait_out", 64'(bus8.wait_out), 64'd0);
        check("rst_io_access", 64'(bus8.io_access), 64'd0);
        check("rst_io_packet", bus8.io_packet, 64'd0);
        check("rst_io_valid", 64'(bus8.io_valid), 64'd0);
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_pkt_count", 64'(cnt8), 64'd0);
        @(posedge clk); #1;
        nreset = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Full-packet mode, one packet: 3 beats, first at t+2
        push8(rand_pkt(2'd0), 1'b1);
        @(negedge clk);
        check("t1_lat_t1", 64'(bus8.io_access), 64'd0);
        @(negedge clk);
        check("t1_lat_t2", 64'(bus8.io_access), 64'd1);
        check("t1_first_valid", 64'(bus8.io_valid), 64'hFF);
        drain8();

        // Data-only mode, datamode 0..3 back to back
        for (int dm = 0; dm < 4; dm++) push8(rand_pkt(2'(dm)), 1'b0);
        drain8();
`ifdef MTX_STATS_EN
        check("stats_after_t2", 64'(cnt8), 64'd5);
`else
        check("stats_off_t2", 64'(cnt8), 64'd0);
`endif

        // tx_en low: in-flight packet completes, buffered packet is held
        push8(rand_pkt(2'd0), 1'b1);
        push8(rand_pkt(2'd3), 1'b0);
        tx_en = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("txen_held_access", 64'(bus8.io_access), 64'd0);
        check("txen_held_busy", 64'(busy8), 64'd1);
        check("txen_wait_out", 64'(bus8.wait_out), 64'd1);
        check("txen_held_beats", 64'(q8.size()), 64'd1);
        tx_en = 1'b1;
        drain8();

        // NW=2, datamode 3, io_wait for 2 cycles on beat 1
        pops2 = 0;
        push2(rand_pkt(2'd3), 1'b0);
        guard = 0;
        @(negedge clk);
        while (!bus2.io_access && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("t3_first_beat_timeout", 64'(guard >= 20), 64'd0);
        @(posedge clk); #1;
        bus2.io_wait = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus2.io_wait = 1'b0;
        guard = 0;
        while ((q2.size() != 0 || busy2) && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check("t3_drain_timeout", 64'(guard >= 50), 64'd0);
        check("t3_beat_count", 64'(pops2), 64'd4);

        // Six pushes against a stalled IO: DEPTH buffered + one in the slicer
        bus8.io_wait = 1'b1;
        for (int i = 0; i < 6; i++) pk[i] = rand_pkt(2'd0);
        n = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            bus8.access_in = (n < 6);
            bus8.packet_in = pk[n % 6];
            bus8.emode     = 1'b1;
            @(negedge clk);
            if (bus8.access_in && !bus8.wait_out) begin
                model(pk[n], 1'b1, 8);
                n++;
            end
            @(posedge clk); #1;
        end
        check("t4_accepted_stalled", 64'(n), 64'(DEPTH + 1));
        @(negedge clk);
        check("t4_wait_out_full", 64'(bus8.wait_out), 64'd1);
        @(posedge clk); #1;
        bus8.io_wait = 1'b0;
        for (int cyc = 0; cyc < 18; cyc++) begin
            bus8.access_in = (n < 6);
            bus8.packet_in = pk[n % 6];
            @(negedge clk);
            check("t4_no_bubble", 64'(bus8.io_access), 64'd1);
            if (bus8.access_in && !bus8.wait_out) begin
                model(pk[n], 1'b1, 8);
                n++;
            end
            @(posedge clk); #1;
        end
        bus8.access_in = 1'b0;
        check("t4_all_accepted", 64'(n), 64'd6);
        drain8();
`ifdef MTX_STATS_EN
        check("stats_after_t4", 64'(cnt8), 64'd13);
`endif

        // Reset during beat 1 of a 3-beat packet, second packet buffered
        push8(rand_pkt(2'd0), 1'b1);
        push8(rand_pkt(2'd0), 1'b1);
        guard = 0;
        @(negedge clk);
        while (!bus8.io_access && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("t5_first_beat_timeout", 64'(guard >= 20), 64'd0);
        @(posedge clk); #1;
        nreset = 1'b0;
        @(negedge clk);
        check("t5_io_access", 64'(bus8.io_access), 64'd0);
        check("t5_busy", 64'(busy8), 64'd0);
        check("t5_pkt_count", 64'(cnt8), 64'd0);
        check("t5_io_valid", 64'(bus8.io_valid), 64'd0);
        q8.delete();
        @(posedge clk); #1;
        nreset = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            check("t5_post_access", 64'(bus8.io_access), 64'd0);
            check("t5_post_busy", 64'(busy8), 64'd0);
        end
        @(posedge clk); #1;

        // Packet counter wrap
`ifdef MTX_STATS_EN
        force u_dut8.r_pkt_count = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release u_dut8.r_pkt_count;
        p = rand_pkt(2'd1);
        push8(p, 1'b0);
        drain8();
        check("t6_wrap", 64'(cnt8), 64'd0);
`else
        p = rand_pkt(2'd1);
        push8(p, 1'b0);
        drain8();
        check("t6_stats_off", 64'(cnt8), 64'd0);
`endif

        check("q8_empty_end", 64'(q8.size()), 64'd0);
        check("q2_empty_end", 64'(q2.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
